// File: rtl/audio_i2s_dac_tx.sv
// Codec-side I2S transmitter: waits for the codec to power up after INIT,
// then serialises one mono sample per frame onto both I2S channels.
// Handshake: INIT is a level request from the sequencer; INIT_FINISH is high
// while samples are being streamed; data_over is high during the left
// half-frame, which tells the sequencer that the current sample has been
// latched and it may present the next one.
module audio_i2s_dac_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SAMPLE_W  = 16,
  parameter int INIT_WAIT = 1000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                INIT,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                INIT_FINISH,
  output logic                data_over,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_PU = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int DW = $clog2(BCLK_DIV);
  localparam int WW = $clog2(INIT_WAIT + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(INIT_WAIT - 1);

  state_t               state_q, state_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;
  logic [5:0]           slot_q, slot_d;
  logic [SAMPLE_W-1:0]  shadow_q, shadow_d;
  logic                 lrck_q, lrck_d;
  logic                 dacdat_q, dacdat_d;
  logic                 data_over_q, data_over_d;
  logic                 init_finish_q, init_finish_d;

  // Next-state logic: power-up wait, then stream while INIT stays high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (INIT) state_d = ST_WAIT_PU;
      end
      ST_WAIT_PU: begin
        if (!INIT)                        state_d = ST_IDLE;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!INIT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: everything is computed from the next state so the registered
  // outputs line up with the state they describe; outside WAIT_PU/RUN all
  // counters and pins fall back to their reset values.
  always_comb begin
    logic [4:0]          pos;
    logic [SAMPLE_W-1:0] shifted;
    wait_cnt_d    = '0;
    div_cnt_d     = '0;
    bclk_d        = 1'b0;
    slot_d        = '0;
    shadow_d      = '0;
    lrck_d        = 1'b0;
    dacdat_d      = 1'b0;
    data_over_d   = 1'b0;
    init_finish_d = 1'b0;
    pos           = '0;
    shifted       = '0;

    if (state_d == ST_WAIT_PU && state_q == ST_WAIT_PU) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (state_d == ST_RUN) begin
      if (state_q != ST_RUN) begin
        // First RUN cycle: slot 0, BCLK low, sample latched with no falling edge.
        shadow_d = sample_in;
      end else begin
        shadow_d  = shadow_q;
        slot_d    = slot_q;
        bclk_d    = bclk_q;
        lrck_d    = lrck_q;
        dacdat_d  = dacdat_q;
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            // Falling BCLK edge: next slot, word select and data bit change together.
            slot_d = slot_q + 6'd1;
            lrck_d = slot_d[5];
            if (slot_d == 6'd0) shadow_d = sample_in;
            // One-bit I2S delay: position 1 carries the MSB.
            pos      = slot_d[4:0];
            shifted  = shadow_q << (pos - 5'd1);
            dacdat_d = (pos != 5'd0) && (32'(pos) <= SAMPLE_W) ? shifted[SAMPLE_W-1] : 1'b0;
          end
        end
      end
      data_over_d   = ~slot_d[5];
      init_finish_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      slot_q        <= '0;
      shadow_q      <= '0;
      lrck_q        <= 1'b0;
      dacdat_q      <= 1'b0;
      data_over_q   <= 1'b0;
      init_finish_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      lrck_q        <= lrck_d;
      dacdat_q      <= dacdat_d;
      data_over_q   <= data_over_d;
      init_finish_q <= init_finish_d;
    end
  end

  assign INIT_FINISH = init_finish_q;
  assign data_over   = data_over_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dacdat_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_audio_i2s_dac_tx.sv
// Bench for audio_i2s_dac_tx: two instances (BCLK_DIV=2 and 3) share the
// inputs; a selector picks which one is being compared. Expected pin values
// come from cycle arithmetic relative to the first RUN cycle and the sample
// that was on sample_in when each frame began.
module tb_audio_i2s_dac_tx;

  logic        clk;
  logic        reset;
  logic        init;
  logic [15:0] sample_in;
  logic        sel;

  logic       a_ifin, a_dover, a_bclk, a_lrck, a_dat;
  logic       b_ifin, b_dover, b_bclk, b_lrck, b_dat;
  logic [1:0] a_dbg, b_dbg;
  logic       obs_ifin, obs_dover, obs_bclk, obs_lrck, obs_dat;

  int          n_assert;
  int          n_fail;
  int          rel;
  logic [15:0] cur_samp;

  audio_i2s_dac_tx #(.BCLK_DIV(2), .SAMPLE_W(16), .INIT_WAIT(8)) dut_a (
    .Clk(clk), .Reset(reset), .INIT(init), .sample_in(sample_in),
    .INIT_FINISH(a_ifin), .data_over(a_dover), .AUD_BCLK(a_bclk),
    .AUD_DACLRCK(a_lrck), .AUD_DACDAT(a_dat), .dbg_state(a_dbg)
  );

  audio_i2s_dac_tx #(.BCLK_DIV(3), .SAMPLE_W(16), .INIT_WAIT(8)) dut_b (
    .Clk(clk), .Reset(reset), .INIT(init), .sample_in(sample_in),
    .INIT_FINISH(b_ifin), .data_over(b_dover), .AUD_BCLK(b_bclk),
    .AUD_DACLRCK(b_lrck), .AUD_DACDAT(b_dat), .dbg_state(b_dbg)
  );

  assign obs_ifin  = sel ? b_ifin  : a_ifin;
  assign obs_dover = sel ? b_dover : a_dover;
  assign obs_bclk  = sel ? b_bclk  : a_bclk;
  assign obs_lrck  = sel ? b_lrck  : a_lrck;
  assign obs_dat   = sel ? b_dat   : a_dat;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s rel=%0d observed=%b expected=%b", tag, rel, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: bit carried in slot s of a frame whose sample is smp.
  function automatic logic exp_dat(input logic [15:0] smp, input int s);
    int p;
    p = s % 32;
    if (p >= 1 && p <= 16) return smp[16-p];
    return 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ifin"},  obs_ifin,  1'b0);
    chk({tag, "_dover"}, obs_dover, 1'b0);
    chk({tag, "_bclk"},  obs_bclk,  1'b0);
    chk({tag, "_lrck"},  obs_lrck,  1'b0);
    chk({tag, "_dat"},   obs_dat,   1'b0);
  endtask

  // Compare the selected DUT against the frame model at cycle 'rel'.
  task automatic check_model(input int d);
    int slot_abs, s;
    slot_abs = rel / (2 * d);
    s        = slot_abs % 64;
    chk("bclk",  obs_bclk,  1'(((rel / d) % 2)));
    chk("lrck",  obs_lrck,  s >= 32);
    chk("dover", obs_dover, s < 32);
    chk("dat",   obs_dat,   exp_dat(cur_samp, s));
    chk("ifin",  obs_ifin,  1'b1);
  endtask

  // Driver: run n checked cycles, optionally changing sample_in at cycle chg_at.
  task automatic run_cycles(input int n, input int d, input int chg_at, input logic [15:0] chg_val);
    for (int i = 0; i < n; i++) begin
      check_model(d);
      if (i == chg_at) sample_in = chg_val;
      step();
      rel++;
      if (rel % (128 * d) == 0) cur_samp = sample_in;
    end
  endtask

  // Count edges until INIT_FINISH rises (bounded), then start frame tracking.
  task automatic wait_finish(input int exp_lat);
    int k;
    for (k = 1; k <= 40; k++) begin
      step();
      if (obs_ifin) break;
    end
    chk_int("init_latency", k, exp_lat);
    rel      = 0;
    cur_samp = sample_in;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rel       = 0;
    cur_samp  = '0;
    sel       = 1'b0;
    reset     = 1'b1;
    init      = 1'b1;
    sample_in = 16'hA5C3;

    // Reset held 3 cycles with INIT high: both instances silent.
    for (int i = 0; i < 3; i++) begin
      step();
      sel = 1'b0; check_idle("rst_a");
      sel = 1'b1; check_idle("rst_b");
    end
    sel   = 1'b0;
    reset = 1'b0;
    wait_finish(9);

    // Frame 0 = A5C3; sample changed at slot 50 must not disturb it.
    run_cycles(256, 2, 200, 16'h1234);
    // Frame 1 = 1234; FFFF presented at slot 10 only lands in frame 2.
    run_cycles(256, 2, 40, 16'hFFFF);
    // Random samples changed at random points in each frame.
    for (int f = 0; f < 3; f++) begin
      run_cycles(256, 2, $urandom_range(0, 255), 16'($urandom));
    end

    // INIT dropped in the middle of slot 20.
    run_cycles(20 * 4 + 1, 2, -1, 16'h0000);
    init = 1'b0;
    step();
    check_idle("drop");
    init = 1'b1;
    wait_finish(9);
    run_cycles(256, 2, -1, 16'h0000);

    // Reset mid-frame, then BCLK_DIV=3 instance with extreme samples.
    run_cycles(37, 2, -1, 16'h0000);
    reset = 1'b1;
    step();
    sel = 1'b0; check_idle("midrst_a");
    sel = 1'b1; check_idle("midrst_b");
    sample_in = 16'h8000;
    step();
    check_idle("rst_hold_b");
    reset = 1'b0;
    wait_finish(9);
    run_cycles(384, 3, 300, 16'h7FFF);
    run_cycles(384, 3, $urandom_range(0, 383), 16'($urandom));
    run_cycles(384, 3, -1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
